ram_readback_checker: RTL and testbench
=======================================

RAM_READBACK_CHECKER -- requirements
Module: ram_readback_checker

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, RAM word width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, RAM address width.
REQ-003 The block SHALL have parameter SET_LEN, default 16, words per data set (1..2^ADDR_W).
REQ-004 The block SHALL have parameter LFSR_SEED, default 8'hA5, expected-data generator seed (nonzero).
REQ-005 The block SHALL have port i_clk, input, 1, the only clock; all logic on its rising edge.
REQ-006 The block SHALL have port i_rst, input, 1; reset is synchronous and active-high.
REQ-007 The block SHALL have port i_set_ready, input, 1, single-cycle pulse: writer has completed one set in RAM.
REQ-008 The block SHALL have port i_stop_system, input, 1, single-cycle pulse: finish the current set, then accept no more.
REQ-009 The block SHALL have port o_rd_en, output, 1, RAM read enable.
REQ-010 The block SHALL have port o_rd_addr, output, ADDR_W, RAM read address.
REQ-011 The block SHALL have port i_rd_data, input, DATA_W, RAM read data, valid exactly 1 cycle after o_rd_en.
REQ-012 The block SHALL have ports o_busy (1), o_set_done (1, pulse), o_sets_checked (32) and o_sets_matched (32), all outputs.

Function
REQ-013 FSM states SHALL be IDLE, READ, DRAIN and DONE.
REQ-014 IDLE->READ SHALL occur when i_set_ready=1 or pending=1, and stopped=0.
REQ-015 In READ: o_rd_en=1; o_rd_addr runs 0..SET_LEN-1, one per cycle; after SET_LEN-1 the FSM goes to DRAIN.
REQ-016 DRAIN SHALL last one cycle (last word compare), then go to DONE; DONE SHALL last one cycle, then go to IDLE.
REQ-017 Latency: i_set_ready sampled in cycle N gives first o_rd_en in N+1 and o_set_done in N+SET_LEN+2.
REQ-018 Expected data: 8-bit Fibonacci LFSR (taps 8,6,5,4), advanced once per compared word; state carries across sets; DATA_W>8 compares zero-extended.
REQ-019 Every cycle following an o_rd_en cycle, i_rd_data SHALL be compared with the expected word; any mismatch clears the set's match flag.
REQ-020 In DONE: o_sets_checked +1; o_sets_matched +1 if match flag set; o_set_done=1 for that cycle only.
REQ-021 Counters SHALL wrap 2^32-1 -> 0 without saturation.
REQ-022 o_busy SHALL be 1 in READ, DRAIN and DONE.
REQ-023 i_set_ready while busy SHALL set a 1-deep pending flag; further pulses while pending=1 are dropped.
REQ-024 pending SHALL clear when IDLE->READ is taken.
REQ-025 i_set_ready and DONE in the same cycle: pending is set and the next set starts on the following IDLE cycle.
REQ-026 i_stop_system SHALL set stopped and clear pending; an in-flight set completes and is counted.
REQ-027 stopped SHALL clear only on reset.
REQ-028 o_rd_addr SHALL hold its last value when o_rd_en=0.

Reset
REQ-029 On i_rst=1 at a clock edge: state IDLE, LFSR=LFSR_SEED, pending=0, stopped=0.
REQ-030 On the same reset: all outputs 0, counters 0.
REQ-031 Reset mid-set SHALL abort the set without counting it.

Configuration
REQ-032 With RAM_CHECKER_ERR_LOG_EN defined, the block SHALL add outputs o_err_valid (1), o_err_addr (ADDR_W), o_err_exp (DATA_W) and o_err_got (DATA_W), capturing the first mismatch since reset and holding it until reset.
REQ-033 Without RAM_CHECKER_ERR_LOG_EN, those ports and their registers SHALL not exist; all other behaviour is identical.

Structure
REQ-034 A shared package ram_sys_pkg SHALL hold the FSM state encoding, the LFSR tap mask and the default seed, shared with the writer side.
REQ-035 The LFSR SHALL be a sub-module ram_lfsr_gen (enable, load-seed, DATA_W output), reused by the writer.

Verification
REQ-036 Reset for 4 cycles, no stimulus for 20 cycles -> o_rd_en never 1; counters 0.
REQ-037 RAM preloaded with the LFSR sequence from 8'hA5, one i_set_ready -> 16 reads at addresses 0..15; o_set_done 18 cycles after the pulse; checked=1, matched=1.
REQ-038 Same as REQ-037 but with word 7 corrupted -> checked=1, matched=0; with the macro, err_addr=7 and err_exp/err_got correct.
REQ-039 Three i_set_ready pulses during one set -> exactly 2 sets run back to back; checked=2.
REQ-040 i_stop_system at read address 5 -> the set completes (checked=1); a later i_set_ready is ignored.
REQ-041 i_rst at read address 9 -> outputs 0, checked=0; the next set uses the LFSR restarted from the seed.

Source files
------------

// File: rtl/ram_sys_pkg.sv
// Shared RAM test-system definitions: checker FSM encoding, LFSR taps and default seed.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a. Imported by both the RAM writer and the readback checker.
package ram_sys_pkg;

   // Readback FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } rd_state_t;

   // 8-bit Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3)
   localparam logic [7:0] LFSR_TAP_MASK     = 8'hB8;
   localparam logic [7:0] LFSR_DEFAULT_SEED = 8'hA5;

   // One LFSR step: shift left, feedback into bit 0
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAP_MASK)};
   endfunction

endpackage

// File: rtl/ram_lfsr_gen.sv
// Expected-data generator: 8-bit Fibonacci LFSR, zero-extended/truncated to DATA_W.
// Latency: o_data is the current state; i_en advances it on the next rising edge.
// Backpressure: none; i_load (seed reload) has priority over i_en.
// Ports: i_clk clock, i_load reload seed, i_en advance one step, o_data current word.
module ram_lfsr_gen
   import ram_sys_pkg::*;
#(
   parameter int         DATA_W = 8,
   parameter logic [7:0] SEED   = LFSR_DEFAULT_SEED
) (
   input  logic              i_clk,
   input  logic              i_load,
   input  logic              i_en,
   output logic [DATA_W-1:0] o_data
);

   logic [7:0] lfsr_q;

   always_ff @(posedge i_clk) begin
      if (i_load) begin
         lfsr_q <= SEED;
      end else if (i_en) begin
         lfsr_q <= lfsr_step(lfsr_q);
      end
   end

   assign o_data = DATA_W'(lfsr_q);

endmodule

// File: rtl/ram_readback_checker.sv
// Reads back one RAM data set per i_set_ready and compares it against the LFSR sequence.
// Latency: set_ready in cycle N -> first o_rd_en in N+1, o_set_done in N+SET_LEN+2.
// Backpressure: one extra set_ready is held pending while busy; further pulses are dropped.
// Ports: i_clk/i_rst (sync, active-high); i_set_ready, i_stop_system pulses;
//        o_rd_en/o_rd_addr/i_rd_data RAM read port (data one cycle after enable);
//        o_busy, o_set_done pulse, o_sets_checked / o_sets_matched wrapping counters.
// Optional: RAM_CHECKER_ERR_LOG_EN adds o_err_valid/o_err_addr/o_err_exp/o_err_got,
//           holding the first mismatch seen since reset.
module ram_readback_checker
   import ram_sys_pkg::*;
#(
   parameter int         DATA_W    = 8,
   parameter int         ADDR_W    = 4,
   parameter int         SET_LEN   = 16,
   parameter logic [7:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_set_ready,
   input  logic              i_stop_system,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_busy,
   output logic              o_set_done,
   output logic [31:0]       o_sets_checked,
   output logic [31:0]       o_sets_matched
`ifdef RAM_CHECKER_ERR_LOG_EN
   ,
   output logic              o_err_valid,
   output logic [ADDR_W-1:0] o_err_addr,
   output logic [DATA_W-1:0] o_err_exp,
   output logic [DATA_W-1:0] o_err_got
`endif
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SET_LEN - 1);

   rd_state_t         state;
   logic              pending;
   logic              stopped;
   logic              cmp_vld;     // i_rd_data this cycle belongs to the set
   logic              match_flag;
   logic [DATA_W-1:0] exp_word;
   logic              word_bad;
   logic              start_set;

   // Expected word sequence; reset reloads the seed so an aborted set restarts cleanly
   ram_lfsr_gen #(
      .DATA_W (DATA_W),
      .SEED   (LFSR_SEED)
   ) u_lfsr (
      .i_clk  (i_clk),
      .i_load (i_rst),
      .i_en   (cmp_vld),
      .o_data (exp_word)
   );

   assign word_bad  = cmp_vld && (i_rd_data != exp_word);
   assign start_set = (state == ST_IDLE) && (i_set_ready || pending) && !stopped;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= ST_IDLE;
         pending        <= 1'b0;
         stopped        <= 1'b0;
         cmp_vld        <= 1'b0;
         match_flag     <= 1'b0;
         o_rd_en        <= 1'b0;
         o_rd_addr      <= '0;
         o_busy         <= 1'b0;
         o_set_done     <= 1'b0;
         o_sets_checked <= '0;
         o_sets_matched <= '0;
      end else begin
         // Read data returns one cycle after each enable
         cmp_vld <= o_rd_en;

         case (state)
            ST_IDLE: begin
               if (start_set) begin
                  state      <= ST_READ;
                  o_rd_en    <= 1'b1;
                  o_rd_addr  <= '0;
                  o_busy     <= 1'b1;
                  match_flag <= 1'b1;
                  pending    <= 1'b0;
               end
            end
            ST_READ: begin
               if (o_rd_addr == LAST_ADDR) begin
                  state   <= ST_DRAIN;
                  o_rd_en <= 1'b0;   // address holds at the last word
               end else begin
                  o_rd_addr <= o_rd_addr + ADDR_W'(1);
               end
            end
            ST_DRAIN: begin
               // Last word is compared this cycle
               state      <= ST_DONE;
               o_set_done <= 1'b1;
            end
            ST_DONE: begin
               state          <= ST_IDLE;
               o_set_done     <= 1'b0;
               o_busy         <= 1'b0;
               o_sets_checked <= o_sets_checked + 32'd1;
               if (match_flag) begin
                  o_sets_matched <= o_sets_matched + 32'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         if (word_bad) begin
            match_flag <= 1'b0;
         end

         // A pulse arriving while busy (including DONE) queues one more set
         if (i_set_ready && (state != ST_IDLE) && !stopped) begin
            pending <= 1'b1;
         end

         // Stop wins over any queued request; the in-flight set still completes
         if (i_stop_system) begin
            stopped <= 1'b1;
            pending <= 1'b0;
         end
      end
   end

`ifdef RAM_CHECKER_ERR_LOG_EN
   logic [ADDR_W-1:0] cmp_addr;   // address of the word currently on i_rd_data

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cmp_addr    <= '0;
         o_err_valid <= 1'b0;
         o_err_addr  <= '0;
         o_err_exp   <= '0;
         o_err_got   <= '0;
      end else begin
         cmp_addr <= o_rd_addr;
         if (word_bad && !o_err_valid) begin
            o_err_valid <= 1'b1;
            o_err_addr  <= cmp_addr;
            o_err_exp   <= exp_word;
            o_err_got   <= i_rd_data;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ram_readback_checker.sv
// Randomized bench for ram_readback_checker with a behavioural RAM and reference model.
// Latency: checks first read at +1 and set_done at +18 cycles after set_ready.
// Backpressure: exercises pending/drop of extra set_ready pulses and stop behaviour.
module tb_ram_readback_checker;

   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 4;
   localparam int SET_LEN = 16;

   logic              i_clk;
   logic              i_rst;
   logic              i_set_ready;
   logic              i_stop_system;
   logic              o_rd_en;
   logic [ADDR_W-1:0] o_rd_addr;
   logic [DATA_W-1:0] i_rd_data;
   logic              o_busy;
   logic              o_set_done;
   logic [31:0]       o_sets_checked;
   logic [31:0]       o_sets_matched;
`ifdef RAM_CHECKER_ERR_LOG_EN
   logic              o_err_valid;
   logic [ADDR_W-1:0] o_err_addr;
   logic [DATA_W-1:0] o_err_exp;
   logic [DATA_W-1:0] o_err_got;
`endif

   ram_readback_checker #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .SET_LEN   (SET_LEN),
      .LFSR_SEED (8'hA5)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_set_ready    (i_set_ready),
      .i_stop_system  (i_stop_system),
      .o_rd_en        (o_rd_en),
      .o_rd_addr      (o_rd_addr),
      .i_rd_data      (i_rd_data),
      .o_busy         (o_busy),
      .o_set_done     (o_set_done),
      .o_sets_checked (o_sets_checked),
      .o_sets_matched (o_sets_matched)
`ifdef RAM_CHECKER_ERR_LOG_EN
      ,
      .o_err_valid    (o_err_valid),
      .o_err_addr     (o_err_addr),
      .o_err_exp      (o_err_exp),
      .o_err_got      (o_err_got)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // ---------------- RAM model: registered read, one cycle latency ----------------
   logic [7:0] ram [SET_LEN];

   always @(posedge i_clk) begin
      i_rd_data <= ram[o_rd_addr];
   end

   // ---------------- reference model ----------------
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] ref_lfsr;
   int         exp_checked;
   int         exp_matched;
   int         rd_count;
   int         done_count;
   int         addr_q [$];
`ifdef RAM_CHECKER_ERR_LOG_EN
   logic       exp_err_vld;
   int         exp_err_addr;
   logic [7:0] exp_err_exp;
   logic [7:0] exp_err_got;
`endif

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      logic fb;
      fb = s[7] ^ s[5] ^ s[4] ^ s[3];
      return {s[6:0], fb};
   endfunction

   // A completed set compares the whole RAM image with the next SET_LEN sequence words
   task automatic model_set();
      logic [7:0] s;
      bit         ok;
      s  = ref_lfsr;
      ok = 1'b1;
      for (int i = 0; i < SET_LEN; i++) begin
         if (ram[i] != s) begin
            ok = 1'b0;
`ifdef RAM_CHECKER_ERR_LOG_EN
            if (!exp_err_vld) begin
               exp_err_vld  = 1'b1;
               exp_err_addr = i;
               exp_err_exp  = s;
               exp_err_got  = ram[i];
            end
`endif
         end
         s = lfsr_next(s);
      end
      ref_lfsr = s;
      exp_checked++;
      if (ok) exp_matched++;
   endtask

   task automatic model_reset();
      ref_lfsr    = 8'hA5;
      exp_checked = 0;
      exp_matched = 0;
      rd_count    = 0;
      done_count  = 0;
      addr_q.delete();
`ifdef RAM_CHECKER_ERR_LOG_EN
      exp_err_vld  = 1'b0;
      exp_err_addr = 0;
      exp_err_exp  = '0;
      exp_err_got  = '0;
`endif
   endtask

   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_rd_en) begin
            rd_count++;
            addr_q.push_back(int'(o_rd_addr));
         end
         if (o_set_done) begin
            done_count++;
            model_set();
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_checked"}, 64'(o_sets_checked), 64'(exp_checked));
      chk({tag, "_matched"}, 64'(o_sets_matched), 64'(exp_matched));
   endtask

   // ---------------- stimulus helpers (called at a falling edge) ----------------
   task automatic fill_ram(input int bad_idx, input logic [7:0] flip);
      logic [7:0] s;
      s = ref_lfsr;
      for (int i = 0; i < SET_LEN; i++) begin
         ram[i] = (i == bad_idx) ? (s ^ flip) : s;
         s = lfsr_next(s);
      end
   endtask

   task automatic apply_reset(input int cycles);
      i_rst = 1'b1;
      repeat (cycles) @(negedge i_clk);
      model_reset();
      i_rst = 1'b0;
   endtask

   task automatic pulse_ready();
      i_set_ready = 1'b1;
      @(negedge i_clk);
      i_set_ready = 1'b0;
   endtask

   task automatic run_set(output int first_rd, output int done_k);
      i_set_ready = 1'b1;
      first_rd = -1;
      done_k   = -1;
      for (int k = 1; k <= 100 && done_k < 0; k++) begin
         @(negedge i_clk);
         i_set_ready = 1'b0;
         if (o_rd_en && first_rd < 0) first_rd = k;
         if (o_set_done) done_k = k;
      end
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (o_set_done) begin
            seen = 1'b1;
            break;
         end
         @(negedge i_clk);
      end
      chk(tag, 64'(seen), 64'd1);
   endtask

   task automatic wait_rd_addr(input string tag, input int a);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (o_rd_en && int'(o_rd_addr) == a) begin
            seen = 1'b1;
            break;
         end
         @(negedge i_clk);
      end
      chk(tag, 64'(seen), 64'd1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int first_rd;
      int done_k;
      int bad;
      int snap_done;
      int snap_rd;
      int k;

      i_rst         = 1'b1;
      i_set_ready   = 1'b0;
      i_stop_system = 1'b0;
      model_reset();
      @(negedge i_clk);

      // Reset state and quiet idle period
      apply_reset(4);
      chk("rst_rd_en",   64'(o_rd_en),        64'd0);
      chk("rst_rd_addr", 64'(o_rd_addr),      64'd0);
      chk("rst_busy",    64'(o_busy),         64'd0);
      chk("rst_done",    64'(o_set_done),     64'd0);
      chk("rst_checked", 64'(o_sets_checked), 64'd0);
      chk("rst_matched", 64'(o_sets_matched), 64'd0);
      repeat (20) @(negedge i_clk);
      chk("idle_rd_count", 64'(rd_count),       64'd0);
      chk("idle_checked",  64'(o_sets_checked), 64'd0);

      // Clean set: latency, address sequence, counters
      fill_ram(-1, 8'h00);
      addr_q.delete();
      run_set(first_rd, done_k);
      chk("clean_first_rd", 64'(first_rd), 64'd1);
      chk("clean_done_lat", 64'(done_k),   64'd18);
      chk("clean_busy_done", 64'(o_busy),  64'd1);
      @(negedge i_clk);
      chk_counters("clean");
      chk("clean_matched_abs", 64'(o_sets_matched), 64'd1);
      chk("clean_nreads", 64'(addr_q.size()), 64'(SET_LEN));
      bad = 0;
      foreach (addr_q[i]) if (addr_q[i] != i) bad++;
      chk("clean_addr_seq", 64'(bad), 64'd0);
      chk("addr_hold", 64'(o_rd_addr), 64'(SET_LEN - 1));
      chk("idle_busy", 64'(o_busy), 64'd0);

      // Word 7 corrupted
      repeat (3) @(negedge i_clk);
      fill_ram(7, 8'h3C);
      run_set(first_rd, done_k);
      chk("bad7_done_lat", 64'(done_k), 64'd18);
      @(negedge i_clk);
      chk_counters("bad7");
`ifdef RAM_CHECKER_ERR_LOG_EN
      chk("err_valid", 64'(o_err_valid), 64'(exp_err_vld));
      chk("err_addr",  64'(o_err_addr),  64'(exp_err_addr));
      chk("err_exp",   64'(o_err_exp),   64'(exp_err_exp));
      chk("err_got",   64'(o_err_got),   64'(exp_err_got));
`endif

      // Three extra pulses during one set: exactly one more set runs
      fill_ram(-1, 8'h00);
      snap_done = done_count;
      snap_rd   = rd_count;
      pulse_ready();
      for (int j = 0; j < 3; j++) begin
         @(negedge i_clk);
         i_set_ready = 1'b1;
         @(negedge i_clk);
         i_set_ready = 1'b0;
      end
      repeat (70) @(negedge i_clk);
      chk("b2b_sets",  64'(done_count - snap_done), 64'd2);
      chk("b2b_reads", 64'(rd_count - snap_rd),     64'(2 * SET_LEN));
      chk_counters("b2b");

      // set_ready in the DONE cycle starts the next set after one IDLE cycle
      fill_ram(-1, 8'h00);
      run_set(first_rd, done_k);
      chk("done_pulse_lat", 64'(done_k), 64'd18);
      i_set_ready = 1'b1;
      k = 0;
      for (int j = 1; j <= 10 && k == 0; j++) begin
         @(negedge i_clk);
         i_set_ready = 1'b0;
         if (o_rd_en) k = j;
      end
      chk("done_pulse_restart", 64'(k), 64'd2);
      wait_done("done_pulse_wait");
      @(negedge i_clk);
      chk_counters("done_pulse");

      // Randomized sets, some with a corrupted word
      for (int r = 0; r < 8; r++) begin
         int         bidx;
         logic [7:0] flip;
         repeat ($urandom_range(0, 5)) @(negedge i_clk);
         bidx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, SET_LEN - 1)) : -1;
         flip = 8'($urandom_range(1, 255));
         fill_ram(bidx, flip);
         run_set(first_rd, done_k);
         chk("rnd_first_rd", 64'(first_rd), 64'd1);
         chk("rnd_done_lat", 64'(done_k),   64'd18);
         @(negedge i_clk);
         chk_counters("rnd");
      end
`ifdef RAM_CHECKER_ERR_LOG_EN
      chk("rnd_err_valid", 64'(o_err_valid), 64'(exp_err_vld));
      chk("rnd_err_addr",  64'(o_err_addr),  64'(exp_err_addr));
      chk("rnd_err_got",   64'(o_err_got),   64'(exp_err_got));
`endif

      // Stop during a set: set completes, later requests ignored
      apply_reset(2);
      fill_ram(-1, 8'h00);
      pulse_ready();
      wait_rd_addr("stop_wait_a5", 5);
      i_stop_system = 1'b1;
      @(negedge i_clk);
      i_stop_system = 1'b0;
      wait_done("stop_wait_done");
      @(negedge i_clk);
      chk_counters("stop");
      chk("stop_checked_abs", 64'(o_sets_checked), 64'd1);
      snap_rd = rd_count;
      pulse_ready();
      repeat (40) @(negedge i_clk);
      chk("stop_no_reads",   64'(rd_count - snap_rd), 64'd0);
      chk("stop_no_set",     64'(o_sets_checked),     64'(exp_checked));
      chk("stop_busy",       64'(o_busy),             64'd0);

      // Reset in the middle of a set, then a fresh set from the seed
      apply_reset(2);
      fill_ram(-1, 8'h00);
      pulse_ready();
      wait_rd_addr("mid_wait_a9", 9);
      apply_reset(1);
      chk("mid_rd_en",   64'(o_rd_en),        64'd0);
      chk("mid_rd_addr", 64'(o_rd_addr),      64'd0);
      chk("mid_busy",    64'(o_busy),         64'd0);
      chk("mid_done",    64'(o_set_done),     64'd0);
      chk("mid_checked", 64'(o_sets_checked), 64'(exp_checked));
      repeat (5) @(negedge i_clk);
      fill_ram(-1, 8'h00);
      run_set(first_rd, done_k);
      chk("post_rst_lat", 64'(done_k), 64'd18);
      @(negedge i_clk);
      chk_counters("post_rst");
      chk("post_rst_matched_abs", 64'(o_sets_matched), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
